// File: rtl/instr_encoder.sv
// RV32IM instruction word assembler with LI expansion and an output word queue.
// Optional M-extension encoding is enabled by defining INSTR_ENC_MEXT_EN.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_kind,
    input  logic [3:0]                    req_op,
    input  logic [4:0]                    req_rd,
    input  logic [4:0]                    req_rs1,
    input  logic [4:0]                    req_rs2,
    input  logic [31:0]                   req_imm,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef INSTR_ENC_MEXT_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif
    localparam logic [31:0] MRET_WORD = 32'h3020_0073;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [31:0]       pend_r;
    logic              err_r;
    logic [31:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r;

    logic [2:0]        f3_s;
    logic              alt_s;
    logic              simm12_s, simm13_s, simm21_s, uimm5_s, uimm12_s;
    logic [19:0]       li_hi_s;
    logic [31:0]       word0_s, word1_s, push_word_s;
    logic              two_words_s, illegal_s;
    logic              has_space_s, accept_s, push_s, pop_s, latch_s;

    assign f3_s     = req_op[2:0];
    assign alt_s    = req_op[3];
    assign simm12_s = (req_imm[31:11] == {21{req_imm[11]}});
    assign simm13_s = (req_imm[31:12] == {20{req_imm[12]}});
    assign simm21_s = (req_imm[31:20] == {12{req_imm[20]}});
    assign uimm5_s  = (req_imm[31:5] == 27'd0);
    assign uimm12_s = (req_imm[31:12] == 20'd0);
    // Rounding by bit 11 compensates for ADDI sign-extending the low part.
    assign li_hi_s  = req_imm[31:12] + {19'd0, req_imm[11]};

    assign has_space_s = (count_r < DEPTH_C);
    assign req_ready   = !rst && (state_r == ST_IDLE) && has_space_s;
    assign accept_s    = req_valid && req_ready;
    assign instr_valid = (count_r != {CW{1'b0}});
    assign pop_s       = instr_valid && instr_ready;
    assign instr       = instr_valid ? mem_r[rd_ptr_r] : 32'd0;
    assign fifo_count  = count_r;
    assign err         = err_r;

    // Field assembly and legality check for the current request.
    always_comb begin
        word0_s     = 32'd0;
        word1_s     = 32'd0;
        two_words_s = 1'b0;
        illegal_s   = 1'b0;
        case (req_kind)
            4'd0: begin
                word0_s   = {(alt_s ? F7_ALT : F7_ZERO), req_rs2, req_rs1, f3_s, req_rd, OP_R};
                illegal_s = alt_s && !((f3_s == 3'b000) || (f3_s == 3'b101));
            end
`ifdef INSTR_ENC_MEXT_EN
            4'd1: begin
                word0_s   = {F7_MULDIV, req_rs2, req_rs1, f3_s, req_rd, OP_R};
                illegal_s = alt_s;
            end
`else
            4'd1: illegal_s = 1'b1;
`endif
            4'd2: begin
                word0_s   = {req_imm[11:0], req_rs1, f3_s, req_rd, OP_I};
                illegal_s = alt_s || !simm12_s;
            end
            4'd3: begin
                word0_s   = {(alt_s ? F7_ALT : F7_ZERO), req_imm[4:0], req_rs1, f3_s, req_rd, OP_I};
                illegal_s = !uimm5_s || !((f3_s == 3'b001) || (f3_s == 3'b101))
                            || (alt_s && (f3_s != 3'b101));
            end
            4'd4: begin
                word0_s   = {req_imm[11:0], req_rs1, f3_s, req_rd, OP_LOAD};
                illegal_s = alt_s || !simm12_s;
            end
            4'd5: begin
                word0_s   = {req_imm[11:5], req_rs2, req_rs1, f3_s, req_imm[4:0], OP_STORE};
                illegal_s = alt_s || !simm12_s;
            end
            4'd6: begin
                word0_s   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, f3_s,
                             req_imm[4:1], req_imm[11], OP_BRANCH};
                illegal_s = alt_s || !simm13_s || req_imm[0]
                            || (f3_s == 3'b010) || (f3_s == 3'b011);
            end
            4'd7: begin
                word0_s   = {req_imm[31:12], req_rd, OP_LUI};
                illegal_s = alt_s || (req_imm[11:0] != 12'd0);
            end
            4'd8: begin
                word0_s   = {req_imm[31:12], req_rd, OP_AUIPC};
                illegal_s = alt_s || (req_imm[11:0] != 12'd0);
            end
            4'd9: begin
                word0_s   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
                illegal_s = alt_s || !simm21_s || req_imm[0];
            end
            4'd10: begin
                word0_s   = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
                illegal_s = alt_s || !simm12_s;
            end
            4'd11: begin
                word0_s   = {req_imm[11:0], req_rs1, 3'b001, req_rd, OP_SYSTEM};
                illegal_s = alt_s || !uimm12_s;
            end
            4'd12: begin
                word0_s   = MRET_WORD;
                illegal_s = 1'b0;
            end
            4'd13: begin
                illegal_s = alt_s;
                word1_s   = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_I};
                if (simm12_s) begin
                    word0_s     = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_I};
                    two_words_s = 1'b0;
                end else begin
                    word0_s     = {li_hi_s, req_rd, OP_LUI};
                    two_words_s = (req_imm[11:0] != 12'd0);
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state and queue-write decisions.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        push_word_s = word0_s;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !illegal_s) begin
                    push_s = 1'b1;
                    if (two_words_s) begin
                        latch_s     = 1'b1;
                        state_nxt_s = ST_EXPAND;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                push_word_s = pend_r;
                if (has_space_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EXPAND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state, pending LI word and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pend_r  <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            err_r   <= accept_s && illegal_s;
            if (latch_s) begin
                pend_r <= word1_s;
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only visible while occupied.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        err;
    logic [2:0]  fifo_count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    instr_encoder #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .err         (err),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        bad;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] kind, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int n = 0;
        req_kind = kind; req_op = op; req_rd = rd;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        int n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        check(tag, instr, exp);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; instr_ready = 1'b0;
        req_kind = 4'd0; req_op = 4'd0; req_rd = 5'd0; req_rs1 = 5'd0;
        req_rs2 = 5'd0; req_imm = 32'd0;

        vecs[0]  = '{4'd0,  4'h8, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h4031_00B3, 1'b0};
        vecs[1]  = '{4'd5,  4'h2, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 32'hFE51_2E23, 1'b0};
        vecs[2]  = '{4'd3,  4'hD, 5'd1, 5'd1, 5'd0, 32'h0000_0003, 32'h4030_D093, 1'b0};
        vecs[3]  = '{4'd9,  4'h0, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0};
        vecs[4]  = '{4'd11, 4'h0, 5'd0, 5'd5, 5'd0, 32'h0000_0300, 32'h3002_9073, 1'b0};
        vecs[5]  = '{4'd7,  4'h0, 5'd2, 5'd0, 5'd0, 32'hABCD_E000, 32'hABCD_E137, 1'b0};
        vecs[6]  = '{4'd2,  4'h0, 5'd1, 5'd0, 5'd0, 32'h0000_07FF, 32'h7FF0_0093, 1'b0};
        vecs[7]  = '{4'd2,  4'h0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0,         1'b1};
        vecs[8]  = '{4'd3,  4'h1, 5'd1, 5'd1, 5'd0, 32'h0000_0020, 32'h0,         1'b1};
        vecs[9]  = '{4'd14, 4'h0, 5'd1, 5'd1, 5'd1, 32'h0000_0000, 32'h0,         1'b1};
        vecs[10] = '{4'd7,  4'h0, 5'd1, 5'd0, 5'd0, 32'h0000_0123, 32'h0,         1'b1};
        vecs[11] = '{4'd6,  4'h2, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0,         1'b1};
        vecs[12] = '{4'd2,  4'h8, 5'd1, 5'd0, 5'd0, 32'h0000_0001, 32'h0,         1'b1};
`ifdef INSTR_ENC_MEXT_EN
        vecs[13] = '{4'd1,  4'h0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0220_81B3, 1'b0};
`else
        vecs[13] = '{4'd1,  4'h0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0,         1'b1};
`endif
        vecs[14] = '{4'd9,  4'h0, 5'd0, 5'd0, 5'd0, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0};
        vecs[15] = '{4'd9,  4'h0, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 32'h0,         1'b1};
        vecs[16] = '{4'd4,  4'h2, 5'd4, 5'd3, 5'd0, 32'hFFFF_F800, 32'h8001_A203, 1'b0};
        vecs[17] = '{4'd10, 4'h0, 5'd1, 5'd6, 5'd0, 32'h0000_0004, 32'h0043_00E7, 1'b0};
        vecs[18] = '{4'd12, 4'hF, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF, 32'h3020_0073, 1'b0};

        step(); step();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        step();
        check("idle_ready", 32'(req_ready), 32'd1);

        // R-ALU with consumer always ready: visible exactly one cycle
        instr_ready = 1'b1;
        send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        check("add_valid", 32'(instr_valid), 32'd1);
        check("add_word", instr, 32'h0020_81B3);
        step();
        check("add_gone", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;

        // Two-word LI
        send(4'd13, 4'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        check("li_expand_ready", 32'(req_ready), 32'd0);
        check("li_count1", 32'(fifo_count), 32'd1);
        step();
        check("li_count2", 32'(fifo_count), 32'd2);
        check("li_idle_ready", 32'(req_ready), 32'd1);
        pop_expect("li_lui", 32'h1234_52B7);
        pop_expect("li_addi", 32'h6782_8293);

        // LI with carry into the upper part
        send(4'd13, 4'd0, 5'd6, 5'd0, 5'd0, 32'h0000_1800);
        step();
        pop_expect("li_carry_lui", 32'h0000_2337);
        pop_expect("li_carry_addi", 32'h8003_0313);

        // LI -1: single ADDI
        send(4'd13, 4'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        check("li_one_ready", 32'(req_ready), 32'd1);
        step();
        check("li_one_count", 32'(fifo_count), 32'd1);
        pop_expect("li_one_word", 32'hFFF0_0093);

        // Branch legal then odd offset
        send(4'd6, 4'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        send(4'd6, 4'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        check("br_odd_err", 32'(err), 32'd1);
        check("br_odd_count", 32'(fifo_count), 32'd1);
        step();
        check("br_err_clear", 32'(err), 32'd0);
        pop_expect("br_word", 32'h0020_8463);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            send(vecs[i].kind, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            if (vecs[i].bad) begin
                check($sformatf("vec%0d_err", i), 32'(err), 32'd1);
                check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd0);
                step();
                check($sformatf("vec%0d_err_clr", i), 32'(err), 32'd0);
            end else begin
                check($sformatf("vec%0d_noerr", i), 32'(err), 32'd0);
                pop_expect($sformatf("vec%0d_word", i), vecs[i].exp);
            end
        end

        // Backpressure: four MRETs fill the queue
        for (int i = 0; i < 4; i++) send(4'd12, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        step();
        check("full_stall", 32'(fifo_count), 32'd4);
        instr_ready = 1'b1;
        check("drain0", instr, 32'h3020_0073);
        step();
        check("first_pop_count", 32'(fifo_count), 32'd3);
        check("first_pop_ready", 32'(req_ready), 32'd1);
        check("drain1", instr, 32'h3020_0073);
        step();
        req_valid = 1'b0;
        check("fifth_accept_count", 32'(fifo_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drain%0d", i + 2), instr, 32'h3020_0073);
            step();
        end
        check("drained_count", 32'(fifo_count), 32'd0);
        check("drained_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;

        // Reset while expanding with two words queued
        send(4'd12, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        send(4'd12, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        send(4'd13, 4'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        check("exp_count", 32'(fifo_count), 32'd3);
        check("exp_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        step();
        check("rst_exp_count", 32'(fifo_count), 32'd0);
        check("rst_exp_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        instr_ready = 1'b1;
        step(); step(); step();
        check("post_rst_count", 32'(fifo_count), 32'd0);
        check("post_rst_valid", 32'(instr_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
